// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
//   - default data width and register count
//   - ALU mode encodings presented on ALU_MODE
//   - sequencer state encoding
package alu_pkg;

  localparam int WIDTH = 8;
  localparam int NREG  = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// General register file for the ALU sequencer.
//   NREG x WIDTH storage, asynchronously cleared to zero.
//   Ports:
//     clk, rst            clock, async active-high reset
//     wr_en/wr_addr/wr_data  single write port (takes effect at the clock edge)
//     rd_a_addr/rd_a_data    operand A read, combinational
//     rd_b_addr/rd_b_data    operand B read, combinational
//     dbg_addr/dbg_data      debug read, combinational
module alu_regfile #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int NREG  = alu_pkg::NREG,
  parameter int RAW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [RAW-1:0]   wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [RAW-1:0]   rd_a_addr,
  output logic [WIDTH-1:0] rd_a_data,
  input  logic [RAW-1:0]   rd_b_addr,
  output logic [WIDTH-1:0] rd_b_data,
  input  logic [RAW-1:0]   dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads see the stored value only, so a write becomes visible the
  // cycle after its edge; operands captured at accept therefore use the
  // pre-write value when DST aliases a source.
  assign rd_a_data = regs_q[rd_a_addr];
  assign rd_b_data = regs_q[rd_b_addr];
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven initiator for an external 8-bit combinational ALU.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a command; loads complete here in one cycle
//   EXEC  | operands/mode presented to the ALU; result captured next edge
//
// Ports:
//   CLK, RST                   clock, async active-high reset
//   CMD_VALID/CMD_READY        command handshake
//   CMD_LOAD                   1 = immediate load, 0 = ALU op
//   CMD_OP/DST/SRCA/SRCB/IMM   command fields
//   ALU_A/ALU_B/ALU_MODE       registered drive to the ALU
//   ALU_OUT                    combinational ALU result
//   RES_VALID/DST/DATA/ZERO    one-cycle result strobe plus held result
//   DBG_ADDR/DBG_DATA          combinational register-file peek
module alu_sequencer #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int NREG  = alu_pkg::NREG,
  parameter int RAW   = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_LOAD,
  input  logic [2:0]       CMD_OP,
  input  logic [RAW-1:0]   CMD_DST,
  input  logic [RAW-1:0]   CMD_SRCA,
  input  logic [RAW-1:0]   CMD_SRCB,
  input  logic [WIDTH-1:0] CMD_IMM,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [2:0]       ALU_MODE,
  input  logic [WIDTH-1:0] ALU_OUT,
  output logic             RES_VALID,
  output logic [RAW-1:0]   RES_DST,
  output logic [WIDTH-1:0] RES_DATA,
  output logic             RES_ZERO,
  input  logic [RAW-1:0]   DBG_ADDR,
  output logic [WIDTH-1:0] DBG_DATA
);

  import alu_pkg::*;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] alu_a_q,     alu_a_d;
  logic [WIDTH-1:0] alu_b_q,     alu_b_d;
  logic [2:0]       alu_mode_q,  alu_mode_d;
  logic [RAW-1:0]   dst_q,       dst_d;
  logic             res_valid_q, res_valid_d;
  logic [RAW-1:0]   res_dst_q,   res_dst_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic             res_zero_q,  res_zero_d;

  logic             cmd_ready;
  logic             accept;
  logic             wr_en;
  logic [RAW-1:0]   wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_a_data;
  logic [WIDTH-1:0] rd_b_data;

  // Ready is forced low during reset so nothing is accepted at the edge
  // where reset releases.
  assign cmd_ready = (state_q == ST_IDLE) && !RST;
  assign accept    = CMD_VALID && cmd_ready;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .RAW   (RAW)
  ) u_regfile (
    .clk       (CLK),
    .rst       (RST),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_a_addr (CMD_SRCA),
    .rd_a_data (rd_a_data),
    .rd_b_addr (CMD_SRCB),
    .rd_b_data (rd_b_data),
    .dbg_addr  (DBG_ADDR),
    .dbg_data  (DBG_DATA)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_mode_d  = alu_mode_q;
    dst_d       = dst_q;
    res_valid_d = 1'b0;
    res_dst_d   = res_dst_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    wr_en       = 1'b0;
    wr_addr     = dst_q;
    wr_data     = ALU_OUT;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (CMD_LOAD) begin
            // Immediate load writes straight through; ALU drive is left alone.
            wr_en   = 1'b1;
            wr_addr = CMD_DST;
            wr_data = CMD_IMM;
          end else begin
            alu_a_d    = rd_a_data;
            alu_b_d    = rd_b_data;
            alu_mode_d = CMD_OP;
            dst_d      = CMD_DST;
            state_d    = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        wr_en   = 1'b1;
        wr_addr = dst_q;
        wr_data = ALU_OUT;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every register write is also reported on the result port.
    if (wr_en) begin
      res_valid_d = 1'b1;
      res_dst_d   = wr_addr;
      res_data_d  = wr_data;
      res_zero_d  = (wr_data == '0);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_mode_q  <= '0;
      dst_q       <= '0;
      res_valid_q <= 1'b0;
      res_dst_q   <= '0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_mode_q  <= alu_mode_d;
      dst_q       <= dst_d;
      res_valid_q <= res_valid_d;
      res_dst_q   <= res_dst_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
    end
  end

  assign CMD_READY = cmd_ready;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_MODE  = alu_mode_q;
  assign RES_VALID = res_valid_q;
  assign RES_DST   = res_dst_q;
  assign RES_DATA  = res_data_q;
  assign RES_ZERO  = res_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic       CMD_LOAD = 1'b0;
  logic [2:0] CMD_OP = 3'b000;
  logic [1:0] CMD_DST = 2'd0;
  logic [1:0] CMD_SRCA = 2'd0;
  logic [1:0] CMD_SRCB = 2'd0;
  logic [7:0] CMD_IMM = 8'h00;
  logic [7:0] ALU_A;
  logic [7:0] ALU_B;
  logic [2:0] ALU_MODE;
  logic [7:0] ALU_OUT;
  logic       RES_VALID;
  logic [1:0] RES_DST;
  logic [7:0] RES_DATA;
  logic       RES_ZERO;
  logic [1:0] DBG_ADDR = 2'd0;
  logic [7:0] DBG_DATA;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  // The external ALU the sequencer drives.
  always_comb begin
    case (ALU_MODE)
      3'b000:  ALU_OUT = ALU_A + ALU_B;
      3'b001:  ALU_OUT = ALU_A - ALU_B;
      3'b010:  ALU_OUT = ALU_A + 8'd1;
      3'b011:  ALU_OUT = ALU_A - 8'd1;
      3'b100:  ALU_OUT = ALU_A & ALU_B;
      3'b101:  ALU_OUT = ALU_A | ALU_B;
      3'b110:  ALU_OUT = ALU_A ^ ALU_B;
      default: ALU_OUT = ~ALU_A;
    endcase
  end

  alu_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_LOAD  (CMD_LOAD),
    .CMD_OP    (CMD_OP),
    .CMD_DST   (CMD_DST),
    .CMD_SRCA  (CMD_SRCA),
    .CMD_SRCB  (CMD_SRCB),
    .CMD_IMM   (CMD_IMM),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ALU_MODE  (ALU_MODE),
    .ALU_OUT   (ALU_OUT),
    .RES_VALID (RES_VALID),
    .RES_DST   (RES_DST),
    .RES_DATA  (RES_DATA),
    .RES_ZERO  (RES_ZERO),
    .DBG_ADDR  (DBG_ADDR),
    .DBG_DATA  (DBG_DATA)
  );

  // Load: accepted at the next edge; returns 1 time unit after it.
  task automatic do_load(input logic [1:0] dst, input logic [7:0] imm);
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_LOAD  = 1'b1;
    CMD_DST   = dst;
    CMD_IMM   = imm;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_LOAD  = 1'b0;
  endtask

  // Op: accepted at edge N; returns 1 time unit after edge N+1.
  task automatic do_op(input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb);
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_LOAD  = 1'b0;
    CMD_OP    = op;
    CMD_DST   = dst;
    CMD_SRCA  = sa;
    CMD_SRCB  = sb;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    vectors++;
    if (CMD_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ready: got %b expected 0", CMD_READY);
    end
    vectors++;
    if ({RES_VALID, RES_DST, RES_DATA, RES_ZERO} !== 12'h000) begin
      miscompares++;
      $display("FAIL rst_res: got %h expected 000", {RES_VALID, RES_DST, RES_DATA, RES_ZERO});
    end
    vectors++;
    if ({ALU_A, ALU_B, ALU_MODE} !== 19'h0) begin
      miscompares++;
      $display("FAIL rst_alu: got %h expected 0", {ALU_A, ALU_B, ALU_MODE});
    end
    RST = 1'b0;
    @(posedge CLK);
    #1;
    vectors++;
    if (CMD_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release_ready: got %b expected 1", CMD_READY);
    end
  endtask

  task automatic test_reset_mid_exec();
    do_load(2'd0, 8'h11);
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_LOAD  = 1'b0;
    CMD_OP    = 3'b000;
    CMD_DST   = 2'd2;
    CMD_SRCA  = 2'd0;
    CMD_SRCB  = 2'd0;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    vectors++;
    if (CMD_READY !== 1'b0 || ALU_A !== 8'h11) begin
      miscompares++;
      $display("FAIL midexec_issue: got ready=%b a=%h expected ready=0 a=11", CMD_READY, ALU_A);
    end
    #2;
    RST = 1'b1;
    #1;
    vectors++;
    if (CMD_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL midexec_ready_in_rst: got %b expected 0", CMD_READY);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    vectors++;
    if (RES_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL midexec_no_result: got %b expected 0", RES_VALID);
    end
    vectors++;
    if (CMD_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL midexec_ready_after: got %b expected 1", CMD_READY);
    end
    vectors++;
    if (ALU_A !== 8'h00) begin
      miscompares++;
      $display("FAIL midexec_alu_a: got %h expected 00", ALU_A);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      DBG_ADDR = 2'(i);
      #1;
      vectors++;
      if (DBG_DATA !== 8'h00) begin
        miscompares++;
        $display("FAIL midexec_reg%0d: got %h expected 00", i, DBG_DATA);
      end
    end
  endtask

  task automatic test_loads();
    do_load(2'd0, 8'h05);
    vectors++;
    if ({RES_VALID, RES_DST, RES_DATA} !== {1'b1, 2'd0, 8'h05}) begin
      miscompares++;
      $display("FAIL load0: got v=%b d=%0d data=%h expected v=1 d=0 data=05", RES_VALID, RES_DST, RES_DATA);
    end
    do_load(2'd1, 8'h03);
    vectors++;
    if ({RES_VALID, RES_DST, RES_DATA} !== {1'b1, 2'd1, 8'h03}) begin
      miscompares++;
      $display("FAIL load1: got v=%b d=%0d data=%h expected v=1 d=1 data=03", RES_VALID, RES_DST, RES_DATA);
    end
    @(posedge CLK);
    #1;
    vectors++;
    if (RES_VALID !== 1'b0 || RES_DATA !== 8'h03) begin
      miscompares++;
      $display("FAIL load_strobe_end: got v=%b data=%h expected v=0 data=03", RES_VALID, RES_DATA);
    end
    DBG_ADDR = 2'd0;
    #1;
    vectors++;
    if (DBG_DATA !== 8'h05) begin
      miscompares++;
      $display("FAIL dbg_r0: got %h expected 05", DBG_DATA);
    end
    DBG_ADDR = 2'd1;
    #1;
    vectors++;
    if (DBG_DATA !== 8'h03) begin
      miscompares++;
      $display("FAIL dbg_r1: got %h expected 03", DBG_DATA);
    end
  endtask

  task automatic test_arith();
    // ADD r2 = r0 + r1, checking the EXEC cycle in between.
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_LOAD  = 1'b0;
    CMD_OP    = 3'b000;
    CMD_DST   = 2'd2;
    CMD_SRCA  = 2'd0;
    CMD_SRCB  = 2'd1;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    vectors++;
    if (CMD_READY !== 1'b0 || RES_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL add_exec: got ready=%b v=%b expected 0 0", CMD_READY, RES_VALID);
    end
    vectors++;
    if ({ALU_A, ALU_B, ALU_MODE} !== {8'h05, 8'h03, 3'b000}) begin
      miscompares++;
      $display("FAIL add_operands: got a=%h b=%h m=%b expected a=05 b=03 m=000", ALU_A, ALU_B, ALU_MODE);
    end
    @(posedge CLK);
    #1;
    vectors++;
    if ({RES_VALID, RES_DST, RES_DATA, RES_ZERO} !== {1'b1, 2'd2, 8'h08, 1'b0}) begin
      miscompares++;
      $display("FAIL add_result: got v=%b d=%0d data=%h z=%b expected v=1 d=2 data=08 z=0", RES_VALID, RES_DST, RES_DATA, RES_ZERO);
    end
    do_op(3'b001, 2'd3, 2'd1, 2'd0);
    vectors++;
    if ({RES_VALID, RES_DST, RES_DATA} !== {1'b1, 2'd3, 8'hFE}) begin
      miscompares++;
      $display("FAIL sub_result: got v=%b d=%0d data=%h expected v=1 d=3 data=fe", RES_VALID, RES_DST, RES_DATA);
    end
  endtask

  task automatic test_wrap();
    do_load(2'd0, 8'hFF);
    do_op(3'b010, 2'd0, 2'd0, 2'd0);
    vectors++;
    if ({RES_DATA, RES_ZERO} !== {8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL inc_wrap: got data=%h z=%b expected data=00 z=1", RES_DATA, RES_ZERO);
    end
    DBG_ADDR = 2'd0;
    #1;
    vectors++;
    if (DBG_DATA !== 8'h00) begin
      miscompares++;
      $display("FAIL inc_wrap_reg: got %h expected 00", DBG_DATA);
    end
    do_load(2'd1, 8'h00);
    do_op(3'b011, 2'd1, 2'd1, 2'd1);
    vectors++;
    if ({RES_DST, RES_DATA, RES_ZERO} !== {2'd1, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL dec_wrap: got d=%0d data=%h z=%b expected d=1 data=ff z=0", RES_DST, RES_DATA, RES_ZERO);
    end
  endtask

  task automatic test_logic();
    do_load(2'd0, 8'hF0);
    do_load(2'd1, 8'h3C);
    // Loads leave the ALU drive from the previous DEC (A was 0x00).
    vectors++;
    if ({ALU_A, ALU_MODE} !== {8'h00, 3'b011}) begin
      miscompares++;
      $display("FAIL load_holds_alu: got a=%h m=%b expected a=00 m=011", ALU_A, ALU_MODE);
    end
    do_op(3'b100, 2'd2, 2'd0, 2'd1);
    vectors++;
    if (RES_DATA !== 8'h30) begin
      miscompares++;
      $display("FAIL and: got %h expected 30", RES_DATA);
    end
    do_op(3'b101, 2'd2, 2'd0, 2'd1);
    vectors++;
    if (RES_DATA !== 8'hFC) begin
      miscompares++;
      $display("FAIL or: got %h expected fc", RES_DATA);
    end
    do_op(3'b110, 2'd2, 2'd0, 2'd1);
    vectors++;
    if (RES_DATA !== 8'hCC) begin
      miscompares++;
      $display("FAIL xor: got %h expected cc", RES_DATA);
    end
    do_op(3'b111, 2'd3, 2'd0, 2'd1);
    vectors++;
    if ({RES_DST, RES_DATA} !== {2'd3, 8'h0F}) begin
      miscompares++;
      $display("FAIL not: got d=%0d data=%h expected d=3 data=0f", RES_DST, RES_DATA);
    end
    vectors++;
    if (ALU_B !== 8'h3C) begin
      miscompares++;
      $display("FAIL not_alu_b: got %h expected 3c", ALU_B);
    end
  endtask

  task automatic test_back_to_back();
    // r0 = r0 + r1 uses the old r0 (F0 + 3C = 2C), and the next op,
    // accepted in that result cycle, sees the new r0 (2C + 3C = 68).
    do_op(3'b000, 2'd0, 2'd0, 2'd1);
    vectors++;
    if ({RES_DST, RES_DATA} !== {2'd0, 8'h2C}) begin
      miscompares++;
      $display("FAIL b2b_first: got d=%0d data=%h expected d=0 data=2c", RES_DST, RES_DATA);
    end
    do_op(3'b000, 2'd2, 2'd0, 2'd1);
    vectors++;
    if ({RES_DST, RES_DATA} !== {2'd2, 8'h68}) begin
      miscompares++;
      $display("FAIL b2b_second: got d=%0d data=%h expected d=2 data=68", RES_DST, RES_DATA);
    end
  endtask

  task automatic test_handshake();
    logic [7:0] rdy_pat;
    int res_cnt;
    int acc;
    rdy_pat = 8'h00;
    res_cnt = 0;
    acc = 0;
    @(posedge CLK);
    #1;
    CMD_LOAD = 1'b0;
    CMD_OP   = 3'b000;
    CMD_DST  = 2'd2;
    CMD_SRCA = 2'd0;
    CMD_SRCB = 2'd1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      rdy_pat[i] = CMD_READY;
      if (RES_VALID === 1'b1) res_cnt++;
      CMD_VALID = (acc < 3);
      if (CMD_READY && CMD_VALID) acc++;
    end
    CMD_VALID = 1'b0;
    vectors++;
    if (rdy_pat !== 8'b1101_0101) begin
      miscompares++;
      $display("FAIL hs_ready_pattern: got %b expected 11010101", rdy_pat);
    end
    vectors++;
    if (res_cnt != 3) begin
      miscompares++;
      $display("FAIL hs_result_count: got %0d expected 3", res_cnt);
    end
    vectors++;
    if ({RES_DST, RES_DATA} !== {2'd2, 8'h68}) begin
      miscompares++;
      $display("FAIL hs_last_result: got d=%0d data=%h expected d=2 data=68", RES_DST, RES_DATA);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_exec();
    test_loads();
    test_arith();
    test_wrap();
    test_logic();
    test_back_to_back();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
